// File: rtl/lut_cfg_pkg.sv
// Shared types and parameter helpers for the LUT configuration loader.
// The CHECK state exists only when LUT_CFG_CHECKSUM_EN is defined.
package lut_cfg_pkg;

`ifdef LUT_CFG_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StCommit} lut_cfg_state_t;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StCommit} lut_cfg_state_t;
`endif

  function automatic int unsigned beats_f(int unsigned mem_size, int unsigned cfg_width);
    return mem_size / cfg_width;
  endfunction

  function automatic bit cfg_legal(int unsigned mem_size, int unsigned cfg_width);
    return (cfg_width != 0) && (mem_size >= cfg_width) && ((mem_size % cfg_width) == 0);
  endfunction

  function automatic int unsigned cnt_width_f(int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/lut_config_loader.sv
// Streams CONFIG_WIDTH-bit beats into a staging register and commits them to config_out with a
// one-cycle cen strobe. Optional trailing XOR check beat enabled by LUT_CFG_CHECKSUM_EN.
module lut_config_loader
  import lut_cfg_pkg::*;
#(
  parameter int unsigned INPUTS       = 4,
  parameter int unsigned MEM_SIZE     = 2 ** INPUTS,
  parameter int unsigned CONFIG_WIDTH = 4
) (
  input  logic                    cclk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CONFIG_WIDTH-1:0] in_data,
  output logic [MEM_SIZE-1:0]     config_out,
  output logic                    cen,
  output logic                    busy,
  output logic                    cfg_err
);

  localparam int unsigned BEATS = beats_f(MEM_SIZE, CONFIG_WIDTH);
  localparam int unsigned CNT_W = cnt_width_f(BEATS);
  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BEATS - 1);

  if (!cfg_legal(MEM_SIZE, CONFIG_WIDTH)) begin : g_bad_cfg
    $error("MEM_SIZE must be a non-zero multiple of CONFIG_WIDTH");
  end

  lut_cfg_state_t        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [MEM_SIZE-1:0]   stage_q, stage_d;
  logic [MEM_SIZE-1:0]   config_q, config_d;
`ifdef LUT_CFG_CHECKSUM_EN
  logic [CONFIG_WIDTH-1:0] xor_q, xor_d;
  logic                    cfg_err_q, cfg_err_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    config_d = config_q;
`ifdef LUT_CFG_CHECKSUM_EN
    xor_d     = xor_q;
    cfg_err_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d   = '0;
        stage_d = '0;
`ifdef LUT_CFG_CHECKSUM_EN
        xor_d = '0;
`endif
        if (start) state_d = StLoad;
      end
      StLoad: begin
        // abort wins over a beat presented in the same cycle
        if (abort) begin
          state_d = StIdle;
        end else if (in_valid) begin
          for (int k = 0; k < BEATS; k++) begin
            if (cnt_q == CNT_W'(k)) stage_d[k*CONFIG_WIDTH +: CONFIG_WIDTH] = in_data;
          end
          cnt_d = cnt_q + CNT_W'(1);
`ifdef LUT_CFG_CHECKSUM_EN
          xor_d = xor_q ^ in_data;
          if (cnt_q == LastBeat) state_d = StCheck;
`else
          if (cnt_q == LastBeat) begin
            state_d  = StCommit;
            config_d = stage_d;
          end
`endif
        end
      end
`ifdef LUT_CFG_CHECKSUM_EN
      StCheck: begin
        if (abort) begin
          state_d = StIdle;
        end else if (in_valid) begin
          if (in_data == xor_q) begin
            state_d  = StCommit;
            config_d = stage_q;
          end else begin
            state_d   = StIdle;
            cfg_err_d = 1'b1;
          end
        end
      end
`endif
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      stage_q  <= '0;
      config_q <= '0;
`ifdef LUT_CFG_CHECKSUM_EN
      xor_q     <= '0;
      cfg_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stage_q  <= stage_d;
      config_q <= config_d;
`ifdef LUT_CFG_CHECKSUM_EN
      xor_q     <= xor_d;
      cfg_err_q <= cfg_err_d;
`endif
    end
  end

`ifdef LUT_CFG_CHECKSUM_EN
  assign in_ready = (state_q == StLoad) || (state_q == StCheck);
  assign cfg_err  = cfg_err_q;
`else
  assign in_ready = (state_q == StLoad);
  assign cfg_err  = 1'b0;
`endif
  assign cen        = (state_q == StCommit);
  assign busy       = (state_q != StIdle);
  assign config_out = config_q;

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed self-checking bench for lut_config_loader (INPUTS=4, CONFIG_WIDTH=4).
// Checksum scenarios run when LUT_CFG_CHECKSUM_EN is defined.
module tb_lut_config_loader;

  logic        cclk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [15:0] config_out;
  logic        cen;
  logic        busy;
  logic        cfg_err;

  int n_vec;
  int n_err;
  int cen_cnt;
  int c0;

  lut_config_loader #(
    .INPUTS      (4),
    .CONFIG_WIDTH(4)
  ) dut (
    .cclk      (cclk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .config_out(config_out),
    .cen       (cen),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  always @(negedge cclk) if (cen === 1'b1) cen_cnt <= cen_cnt + 1;

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 4'h0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full load of v, LSB nibble first; returns in the COMMIT cycle.
  task automatic do_load(input logic [15:0] v, input int gap);
    logic [3:0] xr;
    xr = 4'h0;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      if (k == 2) repeat (gap) tick();
      send_beat(v[k*4 +: 4]);
      xr = xr ^ v[k*4 +: 4];
    end
`ifdef LUT_CFG_CHECKSUM_EN
    send_beat(xr);
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cen_cnt = 0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;
    in_data = 4'h0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    check("rst_config_out", config_out, 16'h0000);
    check("rst_cen", cen, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);

    // Basic back-to-back load
    c0 = cen_cnt;
    pulse_start();
    check("load_in_ready", in_ready, 1'b1);
    check("load_busy", busy, 1'b1);
    check("load_cen_low", cen, 1'b0);
    send_beat(4'hA);
    send_beat(4'h5);
    send_beat(4'hF);
    send_beat(4'h0);
`ifdef LUT_CFG_CHECKSUM_EN
    send_beat(4'h0);
`endif
    check("b2b_cen", cen, 1'b1);
    check("b2b_config", config_out, 16'h0F5A);
    check("b2b_in_ready_commit", in_ready, 1'b0);
    tick();
    check("b2b_cen_fall", cen, 1'b0);
    check("b2b_busy_fall", busy, 1'b0);
    check("b2b_config_hold", config_out, 16'h0F5A);
    check("b2b_cen_count", cen_cnt - c0, 1);

    // Stall of 3 cycles between beats 1 and 2
    c0 = cen_cnt;
    do_load(16'h0F5A, 3);
    check("gap_cen", cen, 1'b1);
    check("gap_config", config_out, 16'h0F5A);
    tick();
    check("gap_cen_count", cen_cnt - c0, 1);

    // Abort after two beats, with a beat presented in the abort cycle
    do_load(16'hFFFF, 0);
    check("ffff_config", config_out, 16'hFFFF);
    tick();
    c0 = cen_cnt;
    pulse_start();
    send_beat(4'h1);
    send_beat(4'h2);
    abort = 1'b1;
    in_valid = 1'b1;
    in_data = 4'h3;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_in_ready", in_ready, 1'b0);
    check("abort_config", config_out, 16'hFFFF);

    // Abort coinciding with the last beat must not commit
    pulse_start();
    send_beat(4'h3);
    send_beat(4'h4);
    send_beat(4'h5);
    abort = 1'b1;
    in_valid = 1'b1;
    in_data = 4'h6;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    check("abort_last_cen", cen, 1'b0);
    check("abort_last_busy", busy, 1'b0);
    tick();
    check("abort_last_config", config_out, 16'hFFFF);
    check("abort_cen_count", cen_cnt - c0, 0);

    // Asynchronous reset mid-load
    pulse_start();
    send_beat(4'h7);
    send_beat(4'h8);
    #3;
    rst = 1'b1;
    #1;
    check("arst_config", config_out, 16'h0000);
    check("arst_busy", busy, 1'b0);
    check("arst_in_ready", in_ready, 1'b0);
    check("arst_cen", cen, 1'b0);
    #2;
    rst = 1'b0;
    tick();
    do_load(16'h1234, 0);
    check("post_rst_cen", cen, 1'b1);
    check("post_rst_config", config_out, 16'h1234);
    tick();

    // start pulsed mid-load is ignored
    pulse_start();
    send_beat(4'h9);
    start = 1'b1;
    send_beat(4'h8);
    start = 1'b0;
    send_beat(4'h7);
    send_beat(4'h6);
`ifdef LUT_CFG_CHECKSUM_EN
    send_beat(4'h0);
`endif
    check("start_ign_cen", cen, 1'b1);
    check("start_ign_config", config_out, 16'h6789);
    tick();
    check("start_ign_busy", busy, 1'b0);

`ifdef LUT_CFG_CHECKSUM_EN
    // Good checksum (1^2^4^8 = F)
    do_load(16'h8421, 0);
    check("cks_cen", cen, 1'b1);
    check("cks_config", config_out, 16'h8421);
    check("cks_err_low", cfg_err, 1'b0);
    tick();
    // Bad checksum
    c0 = cen_cnt;
    pulse_start();
    send_beat(4'h1);
    send_beat(4'h2);
    send_beat(4'h4);
    send_beat(4'h8);
    check("cks_check_ready", in_ready, 1'b1);
    send_beat(4'hE);
    check("cks_bad_err", cfg_err, 1'b1);
    check("cks_bad_cen", cen, 1'b0);
    check("cks_bad_busy", busy, 1'b0);
    check("cks_bad_config", config_out, 16'h8421);
    tick();
    check("cks_err_pulse", cfg_err, 1'b0);
    check("cks_bad_cen_count", cen_cnt - c0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
